counter_updown: RTL and testbench
=================================

# counter_updown

Parametrised successor to the fixed 8-bit enable/set counter: a WIDTH-bit modulo-MODULUS up/down counter with a synchronous load, synchronous clear, wrap flags in both directions and a snapshot capture register. It serves as the timebase and conversion counter for the digital back-end, for example single-slope or ramp conversion counting. The capture port latches the running count on a comparator strobe without stopping the count.

## Interface
- `WIDTH`, 8: counter, setval and capture width in bits (≥2).
- `MODULUS`, 2**WIDTH: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH; elaboration fails outside it.

- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable.
- `dir`  in  1  1 = count up, 0 = count down.
- `set`  in  1  synchronous load of `setval`.
- `setval`  in  WIDTH  load value.
- `clear`  in  1  synchronous clear to 0.
- `capture`  in  1  snapshot strobe.
- `count`  out  WIDTH  registered count.
- `overflow`  out  1  registered up-wrap (or up-saturation) flag.
- `underflow`  out  1  registered down-wrap (or down-saturation) flag.
- `cap_val`  out  WIDTH  last captured count.
- `cap_valid`  out  1  one-cycle pulse after each capture.

## Operation
- While `rst`=0: `count`, `cap_val`, `overflow`, `underflow` and `cap_valid` are all 0, immediately and asynchronously.
- Next-count priority per edge, highest first: `set`, then `clear`, then `en`, then hold.
- `set`:
  - count <= min(setval, MODULUS-1); out-of-range values clamp to MODULUS-1.
  - Held `set` keeps reloading.
  - Both flags are 0 next cycle.
- `clear`: count <= 0; both flags are 0.
- `en`=1, `dir`=1:
  - count+1.
  - At MODULUS-1 it wraps to 0 and `overflow`=1 for that next cycle only.
- `en`=1, `dir`=0:
  - count-1.
  - At 0 it wraps to MODULUS-1 and `underflow`=1 for that next cycle only.
- `en`=0 (no set/clear): count holds; flags are 0.
- `dir` may change on any cycle; it takes effect on that edge.
- Wrap arithmetic is compare-based (count == MODULUS-1, count == 0), not natural WIDTH-bit rollover, so a non-power-of-two MODULUS wraps correctly.
- Capture:
  - On an edge with `capture`=1: cap_val <= count as it was **before** the edge, and `cap_valid`=1 for one cycle.
  - This holds even when `set`/`clear` or a wrap occur on the same edge.
  - `cap_val` otherwise holds.
  - Back-to-back strobes update every cycle and keep `cap_valid` high.

## Timing
- All outputs are registered.
- `count` reflects the edge's action one cycle after input sampling.
- Flags coincide with the count value they describe: count=0 and overflow=1 appear in the same cycle.
- Latency from `capture` to `cap_val`/`cap_valid` is 1 cycle.
- Reset asserted mid-count zeroes all outputs asynchronously. Counting resumes on the first edge after deassertion if `en`=1.

## Configuration
- `COUNTER_SAT_EN` defined: saturating mode.
  - Up at MODULUS-1 holds at MODULUS-1 with `overflow`=1.
  - Down at 0 holds at 0 with `underflow`=1.
  - The flag stays high every cycle that a blocked step is attempted.
- `COUNTER_SAT_EN` undefined: wrap behaviour as in Operation.
- `set`, `clear` and capture behave identically in both modes.

## Test plan
- **Reset and up-count.** Pulse `rst` low, release, `en`=0 for 1 cycle, then `en`=1 and `dir`=1 for N∈[2,60] cycles.
  - count=0 after reset, unchanged while `en`=0, then N.
  - Flags stay 0 throughout.
- **Set and clamp.** WIDTH=8, MODULUS=200, `set`=1 with setval=250 for 2 cycles, release, up-count.
  - count=199 for both cycles.
  - Next cycle count=0 with `overflow`=1; following cycle count=1 with `overflow`=0.
  - With `COUNTER_SAT_EN`: count stays 199 with `overflow`=1.
- **Down wrap.** `set` to 1, then `en`=1, `dir`=0 for 2 cycles.
  - count=0, then count=MODULUS-1 with `underflow`=1 on that cycle only.
- **Priority.** `set`=1, `clear`=1, `en`=1 on one edge with setval=42.
  - count=42.
  - Next edge, `clear`=1 only: count=0.
- **Capture.** count=17 counting up; `capture` on the same edge as `set` (setval=5).
  - cap_val=17 and `cap_valid`=1 for one cycle; count=5.
  - Two consecutive strobes keep `cap_valid` high for 2 cycles with cap_val 5 then 6.
- **Async reset mid-count.** Drop `rst` between clock edges at count=90.
  - All outputs are 0 before the next edge.

Source files
------------

// File: rtl/counter_updown.sv
// counter_updown: modulo-MODULUS up/down counter with load, clear, wrap flags and capture; define COUNTER_SAT_EN to saturate instead of wrap.
module counter_updown #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             set,
  input  logic [WIDTH-1:0] setval,
  input  logic             clear,
  input  logic             capture,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_valid
);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  if (WIDTH < 2 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_params
    $error("counter_updown: illegal WIDTH/MODULUS");
  end
  logic [WIDTH-1:0] count_q, count_d, cap_val_q, cap_val_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d, cap_valid_q, cap_valid_d;
  logic             at_max, at_zero, step_up, step_dn;
  always_comb begin
    at_max      = count_q == CNT_MAX;
    at_zero     = count_q == '0;
    step_up     = !set && !clear && en && dir;
    step_dn     = !set && !clear && en && !dir;
`ifdef COUNTER_SAT_EN
    count_d     = set ? (setval > CNT_MAX ? CNT_MAX : setval) :
                  clear ? '0 :
                  step_up ? (at_max ? CNT_MAX : count_q + 1'b1) :
                  step_dn ? (at_zero ? '0 : count_q - 1'b1) : count_q;
`else
    count_d     = set ? (setval > CNT_MAX ? CNT_MAX : setval) :
                  clear ? '0 :
                  step_up ? (at_max ? '0 : count_q + 1'b1) :
                  step_dn ? (at_zero ? CNT_MAX : count_q - 1'b1) : count_q;
`endif
    overflow_d  = step_up && at_max;
    underflow_d = step_dn && at_zero;
    cap_val_d   = capture ? count_q : cap_val_q;
    cap_valid_d = capture;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      cap_val_q   <= cap_val_d;
      cap_valid_q <= cap_valid_d;
    end
  end
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign cap_val   = cap_val_q;
  assign cap_valid = cap_valid_q;
endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: table-driven scoreboard bench for counter_updown at WIDTH=8, MODULUS=200.
module tb_counter_updown;
  localparam int W = 8;
  localparam int M = 200;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic en, dir, set;
    logic [W-1:0] setval;
    logic clear, capture;
    logic [W-1:0] cnt;
    logic ovf, unf;
    logic [W-1:0] cv;
    logic cvld;
  } vec_t;
  typedef struct {
    logic [W-1:0] cnt;
    logic ovf, unf;
    logic [W-1:0] cv;
    logic cvld;
  } exp_t;
  logic clk, rst, en, dir, set, clear, capture;
  logic [W-1:0] setval, count, cap_val;
  logic overflow, underflow, cap_valid;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  vec_t tbl[$];
  counter_updown #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .set(set), .setval(setval),
    .clear(clear), .capture(capture), .count(count), .overflow(overflow),
    .underflow(underflow), .cap_val(cap_val), .cap_valid(cap_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  function automatic vec_t v(logic e, logic d, logic s, int sv, logic c, logic cp,
                             int cnt, logic o, logic u, int cv, logic cvld);
    vec_t r;
    r.en = e; r.dir = d; r.set = s; r.setval = W'(sv); r.clear = c; r.capture = cp;
    r.cnt = W'(cnt); r.ovf = o; r.unf = u; r.cv = W'(cv); r.cvld = cvld;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, act, req);
    end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".overflow"}, 32'(overflow), 0);
    chk({tag, ".underflow"}, 32'(underflow), 0);
    chk({tag, ".cap_val"}, 32'(cap_val), 0);
    chk({tag, ".cap_valid"}, 32'(cap_valid), 0);
  endtask
  task automatic step(vec_t t, string tag);
    exp_t e;
    @(negedge clk);
    en = t.en; dir = t.dir; set = t.set; setval = t.setval; clear = t.clear; capture = t.capture;
    exp_q.push_back('{cnt: t.cnt, ovf: t.ovf, unf: t.unf, cv: t.cv, cvld: t.cvld});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".count"}, 32'(count), 32'(e.cnt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(e.unf));
    chk({tag, ".cap_val"}, 32'(cap_val), 32'(e.cv));
    chk({tag, ".cap_valid"}, 32'(cap_valid), 32'(e.cvld));
  endtask
  initial begin
    int n;
    rst = 1'b0; en = 0; dir = 0; set = 0; setval = '0; clear = 0; capture = 0;
    tbl.push_back(v(0, 0, 1, 250, 0, 0, 199, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 200, 0, 0, 199, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, SAT ? 199 : 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, SAT ? 199 : 1, SAT, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, SAT ? 0 : 199, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 42, 1, 0, 42, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 17, 0, 0, 17, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 5, 0, 1, 5, 0, 0, 17, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 6, 0, 0, 5, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 7, 0, 0, 6, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 8, 0, 0, 6, 0));
    tbl.push_back(v(1, 1, 0, 0, 1, 1, 0, 0, 0, 8, 1));
    tbl.push_back(v(0, 0, 1, 199, 0, 0, 199, 0, 0, 8, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, SAT ? 199 : 0, 1, 0, 199, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, SAT ? 199 : 0, 0, 0, 199, 0));
    tbl.push_back(v(0, 0, 1, 100, 0, 0, 100, 0, 0, 199, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 101, 0, 0, 199, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 100, 0, 0, 199, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 100, 0, 0, 199, 0));
    tbl.push_back(v(0, 0, 1, 89, 0, 0, 89, 0, 0, 199, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 90, 0, 0, 199, 0));
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    step(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle");
    n = $urandom_range(2, 60);
    for (int i = 1; i <= n; i++) step(v(1, 1, 0, 0, 0, 0, i, 0, 0, 0, 0), "upcount");
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));
    @(negedge clk);
    en = 1'b1; dir = 1'b1; capture = 1'b0; set = 1'b0; clear = 1'b0;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("resume.count", 32'(count), 1);
    chk("resume.cap_valid", 32'(cap_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
